ycr_dmem_arb2: RTL and testbench

YCR_DMEM_ARB2 -- requirements
Module: ycr_dmem_arb2

---
 rtl/ycr_dmem_arb2_if.sv | 26 ++
 rtl/ycr_dmem_arb2.sv | 201 ++++++++++++++++++++
 tb/tb_ycr_dmem_arb2.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycr_dmem_arb2_if.sv
// Data-memory request/response bundle used for both upstream requester ports
// and the shared downstream port of ycr_dmem_arb2.
interface ycr_dmem_arb2_if #(
    parameter int YCR_WB_WIDTH   = 32,
    parameter int YCR_WB_BL_DMEM = 4
) ();
    logic                      dmem_req;
    logic                      dmem_cmd;
    logic [1:0]                dmem_width;
    logic [YCR_WB_WIDTH-1:0]   dmem_addr;
    logic [YCR_WB_BL_DMEM-1:0] dmem_bl;
    logic [YCR_WB_WIDTH-1:0]   dmem_wdata;
    logic                      dmem_req_ack;
    logic [YCR_WB_WIDTH-1:0]   dmem_rdata;
    logic [1:0]                dmem_resp;

    modport master (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_bl, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_bl, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/ycr_dmem_arb2.sv
// Two-master round-robin data-memory arbiter, one downstream transaction at a time.
// Optional response watchdog enabled by defining YCR_DMEM_ARB_TIMEOUT_EN.
module ycr_dmem_arb2 #(
    parameter int TIMEOUT_CYC    = 255,
    parameter int YCR_WB_WIDTH   = 32,
    parameter int YCR_WB_BL_DMEM = 4
) (
    input  logic             core_clk,
    input  logic             core_rst_n,
    ycr_dmem_arb2_if.slave   m0,
    ycr_dmem_arb2_if.slave   m1,
    ycr_dmem_arb2_if.master  s
);
    localparam logic [1:0] RESP_NOTRDY  = 2'd0;
    localparam logic [1:0] RESP_RDY_OK  = 2'd1;
    localparam logic [1:0] RESP_RDY_ER  = 2'd2;
    localparam logic [1:0] RESP_RDY_LOK = 2'd3;
    localparam int         WAIT_W       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                    state_r, state_nxt_s;
    logic                      armed_r;
    logic                      grant_r, grant_nxt_s;
    logic                      last_grant_r, last_grant_nxt_s;
    logic [YCR_WB_BL_DMEM-1:0] beat_cnt_r, beat_cnt_nxt_s, beat_cnt_inc_s;
    logic [YCR_WB_BL_DMEM-1:0] beat_tgt_r, beat_tgt_nxt_s;

    logic                      gm_req_s;
    logic                      gm_cmd_s;
    logic [1:0]                gm_width_s;
    logic [YCR_WB_WIDTH-1:0]   gm_addr_s;
    logic [YCR_WB_BL_DMEM-1:0] gm_bl_s;
    logic [YCR_WB_WIDTH-1:0]   gm_wdata_s;

    logic                      s_req_s;
    logic                      s_cmd_s;
    logic [1:0]                s_width_s;
    logic [YCR_WB_WIDTH-1:0]   s_addr_s;
    logic [YCR_WB_BL_DMEM-1:0] s_bl_s;
    logic [YCR_WB_WIDTH-1:0]   s_wdata_s;
    logic                      ack_fwd_s;
    logic [1:0]                resp_fwd_s;
    logic [YCR_WB_WIDTH-1:0]   rdata_fwd_s;

`ifdef YCR_DMEM_ARB_TIMEOUT_EN
    logic [WAIT_W-1:0]         wait_cnt_r, wait_cnt_nxt_s;
    logic                      timeout_hit_s;
    assign timeout_hit_s = (wait_cnt_r == WAIT_W'(TIMEOUT_CYC - 1));
`else
    logic [WAIT_W-1:0]         timeout_unused_s;
    assign timeout_unused_s = WAIT_W'(TIMEOUT_CYC);
`endif

    assign gm_req_s       = grant_r ? m1.dmem_req   : m0.dmem_req;
    assign gm_cmd_s       = grant_r ? m1.dmem_cmd   : m0.dmem_cmd;
    assign gm_width_s     = grant_r ? m1.dmem_width : m0.dmem_width;
    assign gm_addr_s      = grant_r ? m1.dmem_addr  : m0.dmem_addr;
    assign gm_bl_s        = grant_r ? m1.dmem_bl    : m0.dmem_bl;
    assign gm_wdata_s     = grant_r ? m1.dmem_wdata : m0.dmem_wdata;
    assign beat_cnt_inc_s = beat_cnt_r + YCR_WB_BL_DMEM'(1'b1);

    // Next-state, downstream request and upstream response steering
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        beat_cnt_nxt_s   = beat_cnt_r;
        beat_tgt_nxt_s   = beat_tgt_r;
        s_req_s          = 1'b0;
        s_cmd_s          = 1'b0;
        s_width_s        = 2'd0;
        s_addr_s         = {YCR_WB_WIDTH{1'b0}};
        s_bl_s           = {YCR_WB_BL_DMEM{1'b0}};
        s_wdata_s        = {YCR_WB_WIDTH{1'b0}};
        ack_fwd_s        = 1'b0;
        resp_fwd_s       = RESP_NOTRDY;
        rdata_fwd_s      = {YCR_WB_WIDTH{1'b0}};
`ifdef YCR_DMEM_ARB_TIMEOUT_EN
        wait_cnt_nxt_s   = wait_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // armed_r holds off arbitration for the first edge after reset
                if (armed_r && (m0.dmem_req || m1.dmem_req)) begin
                    state_nxt_s = ST_REQ;
                    if (m0.dmem_req && m1.dmem_req) begin
                        grant_nxt_s = ~last_grant_r;
                    end else begin
                        grant_nxt_s = m1.dmem_req;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!gm_req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    s_req_s   = 1'b1;
                    s_cmd_s   = gm_cmd_s;
                    s_width_s = gm_width_s;
                    s_addr_s  = gm_addr_s;
                    s_bl_s    = gm_bl_s;
                    s_wdata_s = gm_wdata_s;
                    ack_fwd_s = s.dmem_req_ack;
                    if (s.dmem_req_ack) begin
                        state_nxt_s      = ST_RESP;
                        last_grant_nxt_s = grant_r;
                        beat_cnt_nxt_s   = {YCR_WB_BL_DMEM{1'b0}};
                        beat_tgt_nxt_s   = (gm_bl_s == {YCR_WB_BL_DMEM{1'b0}}) ?
                                           YCR_WB_BL_DMEM'(1'b1) : gm_bl_s;
`ifdef YCR_DMEM_ARB_TIMEOUT_EN
                        wait_cnt_nxt_s   = {WAIT_W{1'b0}};
`endif
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
            end
            ST_RESP: begin
                resp_fwd_s  = s.dmem_resp;
                rdata_fwd_s = s.dmem_rdata;
                if (s.dmem_resp != RESP_NOTRDY) begin
                    beat_cnt_nxt_s = beat_cnt_inc_s;
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
                case (s.dmem_resp)
                    RESP_RDY_ER, RESP_RDY_LOK: state_nxt_s = ST_IDLE;
                    RESP_RDY_OK: begin
                        if (beat_cnt_inc_s >= beat_tgt_r) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_RESP;
                        end
                    end
                    default: state_nxt_s = ST_RESP;
                endcase
`ifdef YCR_DMEM_ARB_TIMEOUT_EN
                if (s.dmem_resp == RESP_NOTRDY) begin
                    if (timeout_hit_s) begin
                        resp_fwd_s     = RESP_RDY_ER;
                        rdata_fwd_s    = {YCR_WB_WIDTH{1'b0}};
                        wait_cnt_nxt_s = {WAIT_W{1'b0}};
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1'b1);
                    end
                end else begin
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end
`endif
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_r      <= ST_IDLE;
            armed_r      <= 1'b0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            beat_cnt_r   <= {YCR_WB_BL_DMEM{1'b0}};
            beat_tgt_r   <= {YCR_WB_BL_DMEM{1'b0}};
`ifdef YCR_DMEM_ARB_TIMEOUT_EN
            wait_cnt_r   <= {WAIT_W{1'b0}};
`endif
        end else begin
            state_r      <= state_nxt_s;
            armed_r      <= 1'b1;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            beat_tgt_r   <= beat_tgt_nxt_s;
`ifdef YCR_DMEM_ARB_TIMEOUT_EN
            wait_cnt_r   <= wait_cnt_nxt_s;
`endif
        end
    end

    assign s.dmem_req      = s_req_s;
    assign s.dmem_cmd      = s_cmd_s;
    assign s.dmem_width    = s_width_s;
    assign s.dmem_addr     = s_addr_s;
    assign s.dmem_bl       = s_bl_s;
    assign s.dmem_wdata    = s_wdata_s;

    assign m0.dmem_req_ack = ack_fwd_s & ~grant_r;
    assign m1.dmem_req_ack = ack_fwd_s &  grant_r;
    assign m0.dmem_resp    = grant_r ? RESP_NOTRDY : resp_fwd_s;
    assign m1.dmem_resp    = grant_r ? resp_fwd_s  : RESP_NOTRDY;
    assign m0.dmem_rdata   = grant_r ? {YCR_WB_WIDTH{1'b0}} : rdata_fwd_s;
    assign m1.dmem_rdata   = grant_r ? rdata_fwd_s : {YCR_WB_WIDTH{1'b0}};
endmodule

// File: tb/tb_ycr_dmem_arb2.sv
// Scoreboard bench for ycr_dmem_arb2: expected grants and responses are queued
// by the stimulus and consumed by a negedge monitor.
module tb_ycr_dmem_arb2;
    localparam int         W        = 32;
    localparam int         BLW      = 4;
    localparam logic [1:0] R_NOTRDY = 2'd0;
    localparam logic [1:0] R_OK     = 2'd1;
    localparam logic [1:0] R_ER     = 2'd2;
    localparam logic [1:0] R_LOK    = 2'd3;
    localparam logic       CMD_RD   = 1'b0;
    localparam logic       CMD_WR   = 1'b1;
    localparam logic [1:0] WD_WORD  = 2'd2;

    logic core_clk   = 1'b0;
    logic core_rst_n = 1'b0;
    always #5 core_clk = ~core_clk;

    ycr_dmem_arb2_if #(.YCR_WB_WIDTH(W), .YCR_WB_BL_DMEM(BLW)) m0_if ();
    ycr_dmem_arb2_if #(.YCR_WB_WIDTH(W), .YCR_WB_BL_DMEM(BLW)) m1_if ();
    ycr_dmem_arb2_if #(.YCR_WB_WIDTH(W), .YCR_WB_BL_DMEM(BLW)) s_if ();

    ycr_dmem_arb2 #(.TIMEOUT_CYC(8), .YCR_WB_WIDTH(W), .YCR_WB_BL_DMEM(BLW)) dut (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if)
    );

    typedef struct {
        int             m;
        logic           cmd;
        logic [1:0]     width;
        logic [W-1:0]   addr;
        logic [BLW-1:0] bl;
        logic [W-1:0]   wdata;
    } grant_t;
    typedef struct {
        logic [1:0]   resp;
        logic [W-1:0] rdata;
    } resp_t;

    grant_t gq[$];
    resp_t  rq0[$];
    resp_t  rq1[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    grant_t mon_g;
    resp_t  mon_r;
    int     gm;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic master_req(input int m, input logic cmd, input logic [W-1:0] addr,
                              input logic [BLW-1:0] bl, input logic [W-1:0] wdata);
        grant_t g;
        g.m = m; g.cmd = cmd; g.width = WD_WORD; g.addr = addr; g.bl = bl; g.wdata = wdata;
        gq.push_back(g);
        if (m == 0) begin
            m0_if.dmem_req = 1'b1; m0_if.dmem_cmd = cmd; m0_if.dmem_width = WD_WORD;
            m0_if.dmem_addr = addr; m0_if.dmem_bl = bl; m0_if.dmem_wdata = wdata;
        end else begin
            m1_if.dmem_req = 1'b1; m1_if.dmem_cmd = cmd; m1_if.dmem_width = WD_WORD;
            m1_if.dmem_addr = addr; m1_if.dmem_bl = bl; m1_if.dmem_wdata = wdata;
        end
    endtask

    task automatic exp_resp(input int m, input logic [1:0] r, input logic [W-1:0] d);
        resp_t e;
        e.resp = r; e.rdata = d;
        if (m == 0) rq0.push_back(e); else rq1.push_back(e);
    endtask

    task automatic wait_sreq();
        for (int i = 0; i < 20 && !s_if.dmem_req; i++) tick();
        chk("sreq_seen", {79'd0, s_if.dmem_req}, 80'd1);
    endtask

    // Accept the pending downstream request n cycles after it appears.
    task automatic slave_accept(input int n);
        wait_sreq();
        for (int i = 1; i < n; i++) tick();
        s_if.dmem_req_ack = 1'b1;
        #1;
        gm = m1_if.dmem_req_ack ? 1 : 0;
        tick();
        s_if.dmem_req_ack = 1'b0;
        if (gm == 0) m0_if.dmem_req = 1'b0; else m1_if.dmem_req = 1'b0;
    endtask

    task automatic slave_resp(input logic [1:0] r, input logic [W-1:0] d, input int g);
        s_if.dmem_resp = r; s_if.dmem_rdata = d;
        #3;
        if (g == 0)
            chk("other_side_idle", {s_if.dmem_req, m1_if.dmem_req_ack, m1_if.dmem_resp, m1_if.dmem_rdata}, 80'd0);
        else
            chk("other_side_idle", {s_if.dmem_req, m0_if.dmem_req_ack, m0_if.dmem_resp, m0_if.dmem_rdata}, 80'd0);
        tick();
        s_if.dmem_resp = R_NOTRDY; s_if.dmem_rdata = '0;
    endtask

    task automatic slave_stray(input logic [W-1:0] d);
        s_if.dmem_resp = R_OK; s_if.dmem_rdata = d;
        #3;
        chk("stray_discarded", {m0_if.dmem_resp, m0_if.dmem_rdata, m1_if.dmem_resp, m1_if.dmem_rdata}, 80'd0);
        tick();
        s_if.dmem_resp = R_NOTRDY; s_if.dmem_rdata = '0;
    endtask

    task automatic clear_drives();
        m0_if.dmem_req = 1'b0; m0_if.dmem_cmd = 1'b0; m0_if.dmem_width = 2'd0;
        m0_if.dmem_addr = '0; m0_if.dmem_bl = '0; m0_if.dmem_wdata = '0;
        m1_if.dmem_req = 1'b0; m1_if.dmem_cmd = 1'b0; m1_if.dmem_width = 2'd0;
        m1_if.dmem_addr = '0; m1_if.dmem_bl = '0; m1_if.dmem_wdata = '0;
        s_if.dmem_req_ack = 1'b0; s_if.dmem_resp = R_NOTRDY; s_if.dmem_rdata = '0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {s_if.dmem_req, s_if.dmem_cmd, s_if.dmem_addr[7:0], m0_if.dmem_req_ack,
                   m1_if.dmem_req_ack, m0_if.dmem_resp, m1_if.dmem_resp,
                   m0_if.dmem_rdata[15:0], m1_if.dmem_rdata[15:0]}, 80'd0);
    endtask

    // Monitor: every accepted request and every forwarded response pops the scoreboard
    always @(negedge core_clk) begin
        if (core_rst_n) begin
            if (m0_if.dmem_req_ack || m1_if.dmem_req_ack) begin
                if (gq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_grant: got ack m0=%b m1=%b required none", m0_if.dmem_req_ack, m1_if.dmem_req_ack);
                end else begin
                    mon_g = gq.pop_front();
                    chk("grant_master", {78'd0, m1_if.dmem_req_ack, m0_if.dmem_req_ack},
                        (mon_g.m == 1) ? 80'd2 : 80'd1);
                    chk("grant_fields", {s_if.dmem_req, s_if.dmem_cmd, s_if.dmem_width, s_if.dmem_bl,
                                         s_if.dmem_addr, s_if.dmem_wdata},
                        {1'b1, mon_g.cmd, mon_g.width, mon_g.bl, mon_g.addr, mon_g.wdata});
                end
            end
            if (m0_if.dmem_resp != R_NOTRDY) begin
                if (rq0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_resp_m0: got %0d required none", m0_if.dmem_resp);
                end else begin
                    mon_r = rq0.pop_front();
                    chk("resp_m0", {m0_if.dmem_resp, m0_if.dmem_rdata}, {mon_r.resp, mon_r.rdata});
                end
            end
            if (m1_if.dmem_resp != R_NOTRDY) begin
                if (rq1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_resp_m1: got %0d required none", m1_if.dmem_resp);
                end else begin
                    mon_r = rq1.pop_front();
                    chk("resp_m1", {m1_if.dmem_resp, m1_if.dmem_rdata}, {mon_r.resp, mon_r.rdata});
                end
            end
        end
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        clear_drives();
        master_req(0, CMD_RD, 32'h0000_0100, 4'd1, 32'h0);
        exp_resp(0, R_OK, 32'hDEAD_BEEF);
        #1;
        chk_all_zero("reset_outputs");
        tick();
        core_rst_n = 1'b1;
        tick();
        chk("first_edge_no_grant", {79'd0, s_if.dmem_req}, 80'd0);
        tick();
        chk("second_edge_grant", {79'd0, s_if.dmem_req}, 80'd1);
        slave_accept(2);
        slave_resp(R_OK, 32'hDEAD_BEEF, 0);

        // requester withdraws before acceptance
        m0_if.dmem_req = 1'b1; m0_if.dmem_addr = 32'h0000_0180;
        wait_sreq();
        m0_if.dmem_req = 1'b0;
        #1;
        chk("drop_comb", {79'd0, s_if.dmem_req}, 80'd0);
        tick();
        chk("drop_idle", {79'd0, s_if.dmem_req}, 80'd0);

        // bl==0 behaves as a single beat
        master_req(0, CMD_RD, 32'h0000_0200, 4'd0, 32'h0);
        exp_resp(0, R_OK, 32'h1111_1111);
        slave_accept(1);
        slave_resp(R_OK, 32'h1111_1111, 0);
        slave_stray(32'h2222_2222);

        // round robin with both requesting from reset
        core_rst_n = 1'b0;
        clear_drives();
        tick();
        core_rst_n = 1'b1;
        master_req(0, CMD_RD, 32'h0000_0A00, 4'd1, 32'h0);
        master_req(1, CMD_RD, 32'h0000_0B00, 4'd1, 32'h0);
        exp_resp(0, R_OK, 32'hA0A0_A0A0);
        exp_resp(1, R_OK, 32'hB0B0_B0B0);
        exp_resp(0, R_OK, 32'hC0C0_C0C0);
        exp_resp(1, R_OK, 32'hD0D0_D0D0);
        slave_accept(1);
        master_req(0, CMD_RD, 32'h0000_0C00, 4'd1, 32'h0);
        slave_resp(R_OK, 32'hA0A0_A0A0, 0);
        slave_accept(1);
        master_req(1, CMD_RD, 32'h0000_0D00, 4'd1, 32'h0);
        slave_resp(R_OK, 32'hB0B0_B0B0, 1);
        slave_accept(1);
        slave_resp(R_OK, 32'hC0C0_C0C0, 0);
        slave_accept(1);
        slave_resp(R_OK, 32'hD0D0_D0D0, 1);

        // m1 write burst of four ending in LOK while m0 waits
        master_req(1, CMD_WR, 32'h0000_0300, 4'd4, 32'hCAFE_0001);
        exp_resp(1, R_OK,  32'h0000_0001);
        exp_resp(1, R_OK,  32'h0000_0002);
        exp_resp(1, R_OK,  32'h0000_0003);
        exp_resp(1, R_LOK, 32'h0000_0004);
        slave_accept(1);
        master_req(0, CMD_WR, 32'h0000_0400, 4'd4, 32'h5555_AAAA);
        slave_resp(R_OK,     32'h0000_0001, 1);
        slave_resp(R_NOTRDY, 32'h0000_0099, 1);
        slave_resp(R_OK,     32'h0000_0002, 1);
        slave_resp(R_OK,     32'h0000_0003, 1);
        slave_resp(R_LOK,    32'h0000_0004, 1);

        // queued m0 burst terminated early by an error on beat 2
        exp_resp(0, R_OK, 32'h0000_0011);
        exp_resp(0, R_ER, 32'h0BAD_0BAD);
        slave_accept(1);
        slave_resp(R_OK, 32'h0000_0011, 0);
        slave_resp(R_ER, 32'h0BAD_0BAD, 0);
        chk("idle_after_er", {79'd0, s_if.dmem_req}, 80'd0);
        slave_stray(32'h3333_3333);
        slave_stray(32'h4444_4444);

        // reset pulse in the middle of a response phase
        master_req(0, CMD_RD, 32'h0000_0500, 4'd1, 32'h0);
        slave_accept(1);
        core_rst_n = 1'b0;
        s_if.dmem_resp = R_OK; s_if.dmem_rdata = 32'h1234_5678;
        #1;
        chk_all_zero("reset_mid_resp");
        tick();
        clear_drives();
        master_req(0, CMD_RD, 32'h0000_0E00, 4'd1, 32'h0);
        master_req(1, CMD_RD, 32'h0000_0F00, 4'd1, 32'h0);
        exp_resp(0, R_OK, 32'hE0E0_E0E0);
        exp_resp(1, R_OK, 32'hF0F0_F0F0);
        tick();
        core_rst_n = 1'b1;
        slave_accept(1);
        slave_resp(R_OK, 32'hE0E0_E0E0, 0);
        slave_accept(1);
        slave_resp(R_OK, 32'hF0F0_F0F0, 1);

`ifdef YCR_DMEM_ARB_TIMEOUT_EN
        // silent slave: watchdog error on the eighth waiting cycle
        master_req(1, CMD_RD, 32'h0000_0600, 4'd1, 32'h0);
        exp_resp(1, R_ER, 32'h0);
        slave_accept(1);
        s_if.dmem_rdata = 32'hFFFF_FFFF;
        for (int i = 1; i < 8; i++) begin
            #3;
            chk("timeout_wait", {78'd0, m1_if.dmem_resp}, {78'd0, R_NOTRDY});
            tick();
        end
        #3;
        chk("timeout_fire", {m1_if.dmem_resp, m1_if.dmem_rdata}, {46'd0, R_ER, 32'h0});
        tick();
        s_if.dmem_rdata = '0;
        chk("timeout_idle", {s_if.dmem_req, m1_if.dmem_resp}, 80'd0);
`endif

        tick();
        tick();
        chk("scoreboard_drained", 80'(gq.size() + rq0.size() + rq1.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
